// File: rtl/rb_scb.sv
// Parametrised register bank with N combinational read ports, optional writeback
// bypass, optional hard-zero r0, and an issue scoreboard that stalls on RAW/WAW hazards.
module rb_scb #(
  parameter int DW      = 16,
  parameter int NREGS   = 16,
  parameter int AW      = $clog2(NREGS),
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*DW-1:0]   rd_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_dst,
  input  logic [NRD*AW-1:0]   iss_src,
  input  logic [NRD-1:0]      iss_use,
  output logic                iss_stall,
  output logic [NREGS-1:0]    busy,
  output logic [AW:0]         pend_cnt
);

  localparam bit BYP = (BYPASS != 0);
  localparam bit R0Z = (R0_ZERO != 0);

  logic [DW-1:0]    regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      pend_q;
  logic [AW:0]      pend_d;

  logic             wr_eff_s;
  logic [NREGS-1:0] clr_v_s;
  logic [NREGS-1:0] eff_busy_s;
  logic             src_haz_s;
  logic             accept_s;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int k = 0; k < NREGS; k++) begin
      c = c + {{AW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  function automatic logic is_r0(input logic [AW-1:0] a);
    return R0Z && (a == {AW{1'b0}});
  endfunction

  // Writeback qualification: an r0 write is dropped when r0 is hard-wired to zero.
  always_comb begin
    wr_eff_s = wr_en && !is_r0(wr_addr);
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= {DW{1'b0}};
      end
    end else if (wr_eff_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: hard-zero r0 beats bypass, bypass beats stored contents.
  always_comb begin
    rd_data = {(NRD*DW){1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if (is_r0(rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = {DW{1'b0}};
      end else if (BYP && wr_eff_s && (wr_addr == rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = wr_data;
      end else begin
        rd_data[i*DW +: DW] = regs_q[rd_addr[i*AW +: AW]];
      end
    end
  end

  // Hazard detection against busy bits, minus any producer retiring this cycle.
  always_comb begin
    clr_v_s = {NREGS{1'b0}};
    if (wr_en && BYP) begin
      clr_v_s[wr_addr] = 1'b1;
    end else begin
      clr_v_s = {NREGS{1'b0}};
    end
    eff_busy_s = busy_q & ~clr_v_s;
    if (R0Z) begin
      eff_busy_s[0] = 1'b0;
    end else begin
      eff_busy_s[0] = busy_q[0] & ~clr_v_s[0];
    end
    src_haz_s = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (iss_use[i] && eff_busy_s[iss_src[i*AW +: AW]]) begin
        src_haz_s = 1'b1;
      end else begin
        src_haz_s = src_haz_s;
      end
    end
    iss_stall = iss_en && (eff_busy_s[iss_dst] || src_haz_s);
    accept_s  = iss_en && !iss_stall;
  end

  // Scoreboard next state: clear on writeback, then set on accepted issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (accept_s && !is_r0(iss_dst)) begin
      busy_d[iss_dst] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (R0Z) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d[0] = busy_d[0];
    end
    pend_d = popcount(busy_d);
  end

  // Scoreboard and pending-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREGS{1'b0}};
      pend_q <= {(AW+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_rb_scb.sv
// Directed bench for rb_scb: three instances (bypass, no-bypass, hard-zero r0) share stimulus.
module tb_rb_scb;

  localparam int DW = 16;
  localparam int NREGS = 16;
  localparam int AW = 4;
  localparam int NRD = 2;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic              iss_en;
  logic [AW-1:0]     iss_dst;
  logic [NRD*AW-1:0] iss_src;
  logic [NRD-1:0]    iss_use;

  logic [NRD*DW-1:0] rd_a, rd_b, rd_c;
  logic              st_a, st_b, st_c;
  logic [NREGS-1:0]  bz_a, bz_b, bz_c;
  logic [AW:0]       pc_a, pc_b, pc_c;

  int checks = 0;
  int errors = 0;

  rb_scb #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .R0_ZERO(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_a), .iss_en(iss_en), .iss_dst(iss_dst),
    .iss_src(iss_src), .iss_use(iss_use), .iss_stall(st_a), .busy(bz_a), .pend_cnt(pc_a));

  rb_scb #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .R0_ZERO(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_b), .iss_en(iss_en), .iss_dst(iss_dst),
    .iss_src(iss_src), .iss_use(iss_use), .iss_stall(st_b), .busy(bz_b), .pend_cnt(pc_b));

  rb_scb #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .R0_ZERO(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_c), .iss_en(iss_en), .iss_dst(iss_dst),
    .iss_src(iss_src), .iss_use(iss_use), .iss_stall(st_c), .busy(bz_c), .pend_cnt(pc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
    rd_addr = 8'h00; iss_en = 1'b0; iss_dst = 4'd0; iss_src = 8'h00; iss_use = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_rd", {16'h0000, rd_a[15:0]}, 32'h0);
    chk("rst_busy", {16'h0000, bz_a}, 32'h0);
    chk("rst_pend", {27'd0, pc_a}, 32'h0);

    // Populate state, then reset mid-run
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hAAAA; iss_en = 1'b1; iss_dst = 4'd6;
    tick();
    wr_addr = 4'd5; wr_data = 16'h5555; iss_en = 1'b0;
    tick();
    wr_en = 1'b0; rd_addr = {4'd5, 4'd2};
    #1;
    chk("pre_rst_rd", rd_a, {16'h5555, 16'hAAAA});
    chk("pre_rst_busy", {16'h0000, bz_a}, 32'h0040);
    chk("pre_rst_pend", {27'd0, pc_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd_a, 32'h0);
    chk("mid_rst_busy", {16'h0000, bz_a}, 32'h0);
    chk("mid_rst_pend", {27'd0, pc_a}, 32'd0);
    rst_n = 1'b1;

    // Write r5 then read it back the next cycle
    tick();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr = {4'd0, 4'd5};
    #1;
    chk("rd5_a", {16'h0000, rd_a[15:0]}, 32'h0000BEEF);
    chk("rd5_b", {16'h0000, rd_b[15:0]}, 32'h0000BEEF);

    // Bypass vs. no bypass
    rd_addr = {4'd3, 4'd5}; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    #1;
    chk("byp_a", {16'h0000, rd_a[31:16]}, 32'h00001234);
    chk("nobyp_old_b", {16'h0000, rd_b[31:16]}, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("nobyp_new_b", {16'h0000, rd_b[31:16]}, 32'h00001234);

    // RAW: produce r7, then consume it
    iss_en = 1'b1; iss_dst = 4'd7; iss_use = 2'b00;
    #1;
    chk("raw_first_stall", {31'd0, st_a}, 32'd0);
    tick();
    chk("raw_busy7", {16'h0000, bz_a}, 32'h0080);
    chk("raw_pend1", {27'd0, pc_a}, 32'd1);
    iss_dst = 4'd8; iss_src = {4'd0, 4'd7}; iss_use = 2'b01;
    #1;
    chk("raw_stall_a", {31'd0, st_a}, 32'd1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
    #1;
    chk("raw_wb_a", {31'd0, st_a}, 32'd0);
    chk("raw_wb_b", {31'd0, st_b}, 32'd1);
    chk("raw_wb_c", {31'd0, st_c}, 32'd0);
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    chk("raw_after_busy_a", {16'h0000, bz_a}, 32'h0100);
    chk("raw_after_pend_a", {27'd0, pc_a}, 32'd1);
    chk("raw_after_busy_b", {16'h0000, bz_b}, 32'h0);
    chk("raw_after_pend_b", {27'd0, pc_b}, 32'd0);
    wr_en = 1'b1; wr_addr = 4'd8;
    tick();
    wr_en = 1'b0;

    // WAW / set wins
    iss_en = 1'b1; iss_dst = 4'd4; iss_use = 2'b00;
    tick();
    chk("waw_busy4", {16'h0000, bz_a}, 32'h0010);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
    #1;
    chk("waw_stall_a", {31'd0, st_a}, 32'd0);
    chk("waw_stall_b", {31'd0, st_b}, 32'd1);
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("waw_setwins_a", {16'h0000, bz_a}, 32'h0010);
    chk("waw_pend_a", {27'd0, pc_a}, 32'd1);
    chk("waw_clear_b", {16'h0000, bz_b}, 32'h0);
    wr_en = 1'b1; wr_addr = 4'd4;
    tick();
    wr_en = 1'b0;

    // Hard-zero r0
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr = {4'd5, 4'd0};
    #1;
    chk("r0_byp_c", {16'h0000, rd_c[15:0]}, 32'h0);
    chk("r0_byp_a", {16'h0000, rd_a[15:0]}, 32'h0000FFFF);
    tick();
    wr_en = 1'b0;
    #1;
    chk("r0_rd_c", {16'h0000, rd_c[15:0]}, 32'h0);
    chk("r0_rd_a", {16'h0000, rd_a[15:0]}, 32'h0000FFFF);
    iss_en = 1'b1; iss_dst = 4'd0; iss_use = 2'b00;
    tick();
    chk("r0_busy_c", {16'h0000, bz_c}, 32'h0);
    chk("r0_pend_c", {27'd0, pc_c}, 32'd0);
    chk("r0_busy_a", {16'h0000, bz_a}, 32'h0001);
    iss_dst = 4'd3; iss_src = {4'd0, 4'd0}; iss_use = 2'b01;
    #1;
    chk("r0_src_c", {31'd0, st_c}, 32'd0);
    chk("r0_src_a", {31'd0, st_a}, 32'd1);
    iss_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
    tick();
    wr_en = 1'b0;

    // Unused source is not hazard-checked
    iss_en = 1'b1; iss_dst = 4'd9; iss_use = 2'b00;
    tick();
    iss_dst = 4'd10; iss_src = {4'd9, 4'd1}; iss_use = 2'b01;
    #1;
    chk("unused_src1", {31'd0, st_a}, 32'd0);
    iss_use = 2'b10;
    #1;
    chk("used_src1", {31'd0, st_a}, 32'd1);
    iss_dst = 4'd11; iss_use = 2'b00;
    tick();
    iss_en = 1'b0;
    #1;
    chk("two_busy", {16'h0000, bz_a}, 32'h0A00);
    chk("two_pend", {27'd0, pc_a}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
